// File: rtl/powgen_pkg.sv
// Shared types and constants for the axis_power_gen power-sequence source.
package powgen_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int PKT_LEN_DEF = 16;
  localparam int STRB_MAX    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-strobe mask with the low n_bytes bits set.
  function automatic logic [STRB_MAX-1:0] strb_all_ones(input int n_bytes);
    logic [STRB_MAX-1:0] m;
    m = {STRB_MAX{1'b0}};
    for (int i = 0; i < STRB_MAX; i++) begin
      if (i < n_bytes) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_power_gen_if.sv
// AXI4-Stream bundle carrying the generated power sequence.
interface axis_power_gen_if
  import powgen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/power_mult_ovf.sv
// Combinational acc*base step with overflow detection.
// POWGEN_SATURATE_EN selects clamping to all-ones instead of wrapping.
module power_mult_ovf #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);
  logic [2*DATA_W-1:0] prod_s;

  // Full-width product; any upper bit set means the power left DATA_W.
  always_comb begin
    prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    ovf    = |prod_s[2*DATA_W-1:DATA_W];
`ifdef POWGEN_SATURATE_EN
    if (ovf) begin
      y = {DATA_W{1'b1}};
    end else begin
      y = prod_s[DATA_W-1:0];
    end
`else
    y = prod_s[DATA_W-1:0];
`endif
  end
endmodule

// File: rtl/axis_power_gen.sv
// Framed AXI4-Stream source of base^0, base^1, ... with bounded/continuous runs.
// Optional POWGEN_SATURATE_EN (in power_mult_ovf) clamps on overflow.
module axis_power_gen
  import powgen_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    base,
  input  logic [CNT_W-1:0]     num_beats,
  input  logic                 stop,
  axis_power_gen_if.master     m_axis,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  localparam int PKT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [STRB_MAX-1:0] STRB_ALL = strb_all_ones(STRB_W);
  localparam logic [PKT_W-1:0]    PKT_LAST = PKT_W'(PKT_LEN - 1);
  localparam logic [PKT_W-1:0]    PKT_ONE  = PKT_W'(1'b1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};

  state_e             state_r, state_nxt_s;
  logic [DATA_W-1:0]  base_r, tdata_r, prod_s;
  logic [CNT_W-1:0]   num_r, beat_cnt_r, cnt_nxt_s;
  logic [PKT_W-1:0]   pkt_idx_r, pkt_nxt_s;
  logic               tvalid_r, tlast_r, stop_pend_r;
  logic               ovf_s, hs_s, bounded_last_s, final_s, tlast_nxt_s;

  // tdata_r doubles as the accumulator: the presented beat is the current power.
  power_mult_ovf #(.DATA_W(DATA_W)) u_mult (
    .a   (tdata_r),
    .b   (base_r),
    .y   (prod_s),
    .ovf (ovf_s)
  );

  // Handshake, final-beat detection and the framing of the following beat.
  always_comb begin
    hs_s           = tvalid_r & m_axis.tready;
    bounded_last_s = (num_r != CNT_ZERO) && (beat_cnt_r == (num_r - CNT_ONE));
    final_s        = hs_s & (bounded_last_s | (tlast_r & (stop_pend_r | stop)));
    cnt_nxt_s      = beat_cnt_r + CNT_ONE;
    if (pkt_idx_r == PKT_LAST) begin
      pkt_nxt_s = {PKT_W{1'b0}};
    end else begin
      pkt_nxt_s = pkt_idx_r + PKT_ONE;
    end
    tlast_nxt_s = (pkt_nxt_s == PKT_LAST) ||
                  ((num_r != CNT_ZERO) && (cnt_nxt_s == (num_r - CNT_ONE)));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (final_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run parameters, beat counters, AXIS output registers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r      <= {DATA_W{1'b0}};
      num_r       <= CNT_ZERO;
      tdata_r     <= {DATA_W{1'b0}};
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      pkt_idx_r   <= {PKT_W{1'b0}};
      beat_cnt_r  <= CNT_ZERO;
      stop_pend_r <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_nxt_s != IDLE);
      done <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            base_r      <= base;
            num_r       <= num_beats;
            tdata_r     <= {{(DATA_W-1){1'b0}}, 1'b1};
            tvalid_r    <= 1'b1;
            tlast_r     <= (PKT_LEN == 1) || (num_beats == CNT_ONE);
            pkt_idx_r   <= {PKT_W{1'b0}};
            beat_cnt_r  <= CNT_ZERO;
            stop_pend_r <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            stop_pend_r <= 1'b1;
          end
          if (hs_s) begin
            tdata_r    <= prod_s;
            pkt_idx_r  <= pkt_nxt_s;
            beat_cnt_r <= cnt_nxt_s;
            if (ovf_s) begin
              overflow <= 1'b1;
            end
            // The final handshake retires the stream; no further beat is offered.
            if (final_s) begin
              tvalid_r <= 1'b0;
              tlast_r  <= 1'b0;
            end else begin
              tlast_r  <= tlast_nxt_s;
            end
          end
        end
        DONE: begin
          stop_pend_r <= 1'b0;
        end
        default: begin
          tvalid_r    <= 1'b0;
          tlast_r     <= 1'b0;
          stop_pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.tdata  = tdata_r;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tlast  = tlast_r;
  assign m_axis.tstrb  = STRB_ALL[STRB_W-1:0];

endmodule

// File: tb/tb_axis_power_gen.sv
// Directed bench for axis_power_gen: beat-list model per run plus per-cycle compare.
module tb_axis_power_gen;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int PL = 4;
`ifdef POWGEN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, stop_a = 1'b0, stop_b = 1'b0;
  logic [DW-1:0] base = 32'd0;
  logic [CW-1:0] num_beats = 16'd0;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;

  always #5 clk = ~clk;

  axis_power_gen_if #(.DATA_W(DW)) ax_a ();
  axis_power_gen_if #(.DATA_W(DW)) ax_b ();

  axis_power_gen #(.DATA_W(DW), .PKT_LEN(PL), .CNT_W(CW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base(base), .num_beats(num_beats),
    .stop(stop_a), .m_axis(ax_a), .busy(busy_a), .done(done_a), .overflow(ovf_a));

  axis_power_gen #(.DATA_W(DW), .PKT_LEN(1), .CNT_W(CW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base(base), .num_beats(num_beats),
    .stop(stop_b), .m_axis(ax_b), .busy(busy_b), .done(done_b), .overflow(ovf_b));

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int run_base = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  logic [DW-1:0] exp_data[$];
  bit            exp_last[$];
  bit            exp_ovf[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int idx();
    return hs_cnt - run_base;
  endfunction

  // Expected beats of a run: powers of b, framed every PL beats, ended by length or stop.
  function automatic void build(input logic [DW-1:0] b, input int n, input int stop_at);
    longint unsigned v, p;
    bit of, last;
    exp_data.delete(); exp_last.delete(); exp_ovf.delete();
    v = 64'd1; of = 1'b0;
    for (int k = 0; k < 64; k++) begin
      last = ((k % PL) == PL - 1) || (n != 0 && k == n - 1);
      exp_data.push_back(v[DW-1:0]);
      exp_last.push_back(last);
      exp_ovf.push_back(of);
      if ((n != 0 && k == n - 1) || (stop_at >= 0 && k >= stop_at && last)) break;
      p = v * 64'(b);
      if (p > 64'hFFFF_FFFF) begin
        of = 1'b1;
        v  = SAT ? 64'hFFFF_FFFF : (p & 64'hFFFF_FFFF);
      end else begin
        v = p;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (ax_a.tvalid && ax_a.tready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      ax_a.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en && ax_a.tvalid) begin
      if (idx() < exp_data.size()) begin
        chk($sformatf("tdata[%0d]", idx()), 64'(ax_a.tdata), 64'(exp_data[idx()]));
        chk($sformatf("tlast[%0d]", idx()), 64'(ax_a.tlast), 64'(exp_last[idx()]));
        chk($sformatf("overflow[%0d]", idx()), 64'(ovf_a), 64'(exp_ovf[idx()]));
      end else begin
        chk("extra_beat", 64'(ax_a.tvalid), 64'd0);
      end
    end
  end

  task automatic run_a(input string name, input logic [DW-1:0] b, input int n,
                       input int stop_at, input bit rnd, input int poke_at);
    bit stopped, poked;
    stopped = 1'b0; poked = 1'b0;
    @(negedge clk);
    rand_rdy = rnd; base = b; num_beats = CW'(n);
    build(b, n, stop_at);
    run_base = hs_cnt; mon_en = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({name, " tvalid_after_start"}, 64'(ax_a.tvalid), 64'd1);
    chk({name, " busy"}, 64'(busy_a), 64'd1);
    for (int c = 0; c < 400; c++) begin
      if (idx() >= exp_data.size()) break;
      stop_a  = (stop_at >= 0 && idx() == stop_at && !stopped);
      if (stop_a) stopped = 1'b1;
      start_a = (poke_at >= 0 && idx() == poke_at && !poked);
      if (start_a) begin
        poked = 1'b1; base = 32'd7; num_beats = 16'd2;
      end
      @(negedge clk);
    end
    stop_a = 1'b0; start_a = 1'b0;
    chk({name, " beats"}, 64'(idx()), 64'(exp_data.size()));
    chk({name, " done"}, 64'(done_a), 64'd1);
    chk({name, " busy_in_done"}, 64'(busy_a), 64'd1);
    chk({name, " tvalid_off"}, 64'(ax_a.tvalid), 64'd0);
    @(negedge clk);
    chk({name, " done_clear"}, 64'(done_a), 64'd0);
    chk({name, " idle"}, 64'(busy_a), 64'd0);
    mon_en = 1'b0; rand_rdy = 1'b0;
  endtask

  logic [DW-1:0] b_exp [3];

  initial begin
    ax_b.tready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst tvalid", 64'(ax_a.tvalid), 64'd0);
    chk("rst tdata", 64'(ax_a.tdata), 64'd0);
    chk("rst tlast", 64'(ax_a.tlast), 64'd0);
    chk("rst tstrb", 64'(ax_a.tstrb), 64'hF);
    chk("rst busy", 64'(busy_a), 64'd0);
    chk("rst done", 64'(done_a), 64'd0);
    chk("rst overflow", 64'(ovf_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_a("bounded", 32'd3, 4, -1, 1'b0, -1);
    chk("pin bounded beat3", 64'(exp_data[3]), 64'd27);
    chk("pin bounded last3", 64'(exp_last[3]), 64'd1);
    chk("bounded overflow", 64'(ovf_a), 64'd0);

    run_a("backpressure", 32'd2, 8, -1, 1'b1, -1);
    chk("pin bp beat7", 64'(exp_data[7]), 64'd128);

    run_a("overflow", 32'd3, 22, -1, 1'b0, -1);
    chk("pin ovf beat20", 64'(exp_data[20]), 64'd3486784401);
    chk("pin ovf beat21", 64'(exp_data[21]), SAT ? 64'd4294967295 : 64'd1870418611);
    chk("pin ovf flag21", 64'(exp_ovf[21]), 64'd1);
    chk("overflow sticky", 64'(ovf_a), 64'd1);

    @(negedge clk); stop_a = 1'b1;
    @(negedge clk); stop_a = 1'b0;
    run_a("idle_stop", 32'd2, 6, -1, 1'b0, -1);
    chk("overflow cleared by start", 64'(ovf_a), 64'd0);

    run_a("cont_stop", 32'd2, 0, 5, 1'b0, -1);
    chk("pin stop beats", 64'(exp_data.size()), 64'd8);
    chk("pin stop beat7", 64'(exp_data[7]), 64'd128);
    run_a("cont_stop_bp", 32'd2, 0, 5, 1'b1, -1);
    run_a("stop_on_last", 32'd3, 0, 3, 1'b0, -1);
    run_a("start_busy", 32'd3, 10, -1, 1'b0, 2);
    run_a("base0", 32'd0, 3, -1, 1'b0, -1);
    chk("pin base0 beat1", 64'(exp_data[1]), 64'd0);
    run_a("base1", 32'd1, 5, -1, 1'b1, -1);

    // Reset mid-run while beat 3 is on the bus with overflow already raised.
    @(negedge clk);
    base = 32'd65536; num_beats = 16'd0;
    build(32'd65536, 0, -1);
    run_base = hs_cnt; mon_en = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (idx() == 3) break;
      @(negedge clk);
    end
    chk("pre-rst beat index", 64'(idx()), 64'd3);
    chk("pre-rst tvalid", 64'(ax_a.tvalid), 64'd1);
    chk("pre-rst overflow", 64'(ovf_a), 64'd1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst tvalid", 64'(ax_a.tvalid), 64'd0);
    chk("async rst busy", 64'(busy_a), 64'd0);
    chk("async rst overflow", 64'(ovf_a), 64'd0);
    chk("async rst tlast", 64'(ax_a.tlast), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_a("after_rst", 32'd3, 2, -1, 1'b0, -1);

    // Single-beat packets: every beat carries tlast.
    b_exp[0] = 32'd1; b_exp[1] = 32'd5; b_exp[2] = 32'd25;
    @(negedge clk);
    base = 32'd5; num_beats = 16'd3; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("pkt1 tvalid[%0d]", k), 64'(ax_b.tvalid), 64'd1);
      chk($sformatf("pkt1 tdata[%0d]", k), 64'(ax_b.tdata), 64'(b_exp[k]));
      chk($sformatf("pkt1 tlast[%0d]", k), 64'(ax_b.tlast), 64'd1);
      @(negedge clk);
    end
    chk("pkt1 done", 64'(done_b), 64'd1);
    chk("pkt1 busy", 64'(busy_b), 64'd1);
    chk("pkt1 overflow", 64'(ovf_b), 64'd0);
    chk("pkt1 tstrb", 64'(ax_b.tstrb), 64'hF);
    @(negedge clk);
    chk("pkt1 idle", 64'(busy_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_power_gen.md
# axis_power_gen

Upstream source stage that generates the integer power sequence base^0, base^1, base^2, … and presents it as a framed AXI4-Stream master, one beat per cycle when not back-pressured. It feeds the power-stream AXI-Stream FIFO and honours full valid/ready handshaking. Runs are started by a pulse and are bounded or continuous. Packets are delimited with tlast every PKT_LEN beats.

## Interface
- DATA_W, 32, beat width in bits. Must be a multiple of 8.
- PKT_LEN, 16, beats per packet (≥1). tlast marks the last beat of each packet.
- CNT_W, 16, width of the run-length counter.

Ports:
- clk  in  1  single clock. All logic is on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request. Sampled only in IDLE.
- base  in  DATA_W  multiplier. Captured on an accepted start.
- num_beats  in  CNT_W  run length, captured on start. 0 means continuous.
- stop  in  1  pulse. Ends a continuous or bounded run at the next packet boundary.
- m_axis_tdata  out  DATA_W  current power value.
- m_axis_tstrb  out  DATA_W/8  constant all-ones.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  end of packet.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a run ends.
- overflow  out  1  sticky. Set when any product exceeds DATA_W bits. Cleared by the next accepted start.

## Operation
- States:
  - IDLE: start → RUN. Captures base and num_beats, loads acc=1, clears beat counters and overflow.
  - RUN: presents acc. A handshake (tvalid & tready) advances the sequence. The final beat handshake → DONE.
  - DONE: pulses done for one cycle, then → IDLE.
- Final beat: beat index num_beats-1 when num_beats≠0. After stop, the final beat is the next tlast beat.
- tlast is high when pkt_idx==PKT_LEN-1, or when the beat is the final beat of a bounded run. A bounded run therefore always terminates its packet.
- stop latches a stop_pend flag. The generator continues until the next beat carrying tlast completes its handshake, then → DONE. stop in IDLE is ignored.
- On handshake:
  - acc ← acc*base, truncated to DATA_W.
  - pkt_idx wraps at PKT_LEN-1 → 0.
  - beat_cnt increments.
  - If the full 2·DATA_W product has nonzero upper bits, overflow ← 1.
- start while busy is ignored. base and num_beats changes during a run are ignored.
- Edge bases: base=0 gives 1,0,0,…; base=1 gives all ones.
- AXIS rules:
  - Once tvalid is high, tdata and tlast hold stable until the handshake.
  - tvalid never depends combinationally on tready.

## Timing
- Reset values: tvalid=0, tdata=0, tlast=0, tstrb=all-ones, busy=0, done=0, overflow=0. State is IDLE, stop_pend=0.
- rst mid-run clears everything asynchronously. A partial packet is abandoned; no tlast is emitted.
- Latency:
  - start is sampled at edge N. tvalid=1 with tdata=1 is visible after edge N.
  - Next value is registered at the handshake edge, giving one beat per cycle with tready held high.
- A tready stall holds the beat indefinitely; no values are skipped or repeated.
- Final handshake at edge M: tvalid=0, busy=1, done=1 after M. busy=0, done=0 after M+1. The earliest new start is sampled at edge M+2.
- stop coinciding with a tlast handshake ends the run at that beat.

## Configuration
- POWGEN_SATURATE_EN:
  - Defined: on overflow, acc clamps to all-ones and stays there for the rest of the run.
  - Undefined: acc wraps modulo 2^DATA_W.
- overflow is set identically in both builds.

## Structure
- Package powgen_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default DATA_W and PKT_LEN localparams;
  - the all-ones tstrb constant function.
- Sub-module power_mult_ovf takes acc and base. It returns the DATA_W result (wrapped or saturated per the macro) and an ovf flag. It is purely combinational.
- The top module holds the FSM, counters, AXIS output registers and status flags.

## Test plan
- Bounded run: base=3, num_beats=4, tready=1. Expect tdata 1, 3, 9, 27 on consecutive cycles, tlast on 27, done one cycle later, overflow=0.
- Backpressure: base=2, num_beats=8, tready random 50%. Expect 1..128 in order, tdata/tlast stable during stalls, no duplicates.
- Overflow: base=3, num_beats=22, DATA_W=32. Beat 20 = 3486784401. Beat 21 = 1870418611 (wrap) or 4294967295 (saturate). overflow=1 from beat 21.
- Continuous with stop: PKT_LEN=4, num_beats=0, base=2, stop pulsed at beat index 5. Beats continue through index 7 (=128, tlast) then done, tvalid=0.
- Reset mid-run: assert rst during beat 3 with tvalid high. tvalid, busy and overflow go 0 without a clock edge. A new start gives tdata=1 first.
- Edge cases: start pulsed while busy is ignored (sequence unbroken). base=0, num_beats=3 gives 1, 0, 0. PKT_LEN=1 gives tlast on every beat.
